// File: rtl/datapath_pkg.sv
// ---------------------------------------------------------------------------
// datapath_pkg
// Shared definitions for the single-bus CPU datapath:
//   - WORD_W     : datapath word width (bus, registers, RAM words)
//   - GPR_COUNT  : number of general-purpose registers
//   - ALU_*      : 5-bit ALU opcodes presented on CONTROL
//   - word_t     : convenience type for one datapath word
// ---------------------------------------------------------------------------
package datapath_pkg;

    localparam int WORD_W    = 32;
    localparam int GPR_COUNT = 16;
    localparam int GPR_IDX_W = 4;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SUB  = 5'b00001;
    localparam logic [4:0] ALU_AND  = 5'b00010;
    localparam logic [4:0] ALU_OR   = 5'b00011;
    localparam logic [4:0] ALU_SHR  = 5'b00100;
    localparam logic [4:0] ALU_SHRA = 5'b00101;
    localparam logic [4:0] ALU_SHL  = 5'b00110;
    localparam logic [4:0] ALU_ROR  = 5'b00111;
    localparam logic [4:0] ALU_ROL  = 5'b01000;
    localparam logic [4:0] ALU_NEG  = 5'b01001;
    localparam logic [4:0] ALU_NOT  = 5'b01010;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/datapath_alu.sv
// ---------------------------------------------------------------------------
// datapath_alu
// Purely combinational ALU for the single-bus datapath.
// Ports:
//   a      in  WORD_W  first operand (the Y register)
//   b      in  WORD_W  second operand (the shared bus)
//   op     in  5       opcode, see ALU_* in datapath_pkg
//   result out WORD_W  low word of the operation; unknown opcodes pass b
// Shift and rotate amounts come from b[4:0].
// ---------------------------------------------------------------------------
module datapath_alu
    import datapath_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic [4:0]        op,
    output logic [WORD_W-1:0] result
);

    logic [4:0]               shamt;
    logic signed [WORD_W-1:0] a_signed;
    logic signed [WORD_W-1:0] sra_val;
    logic [2*WORD_W-1:0]      a_twice;
    logic [2*WORD_W-1:0]      ror_full;
    logic [2*WORD_W-1:0]      rol_full;

    assign shamt    = b[4:0];
    assign a_signed = a;
    assign sra_val  = a_signed >>> shamt;

    // Rotates are done by shifting a doubled copy of the operand: the bits
    // that fall off one end reappear from the second copy, so a rotate by
    // zero needs no special case.
    assign a_twice  = {a, a};
    assign ror_full = a_twice >> shamt;
    assign rol_full = a_twice << shamt;

    always_comb begin
        result = b;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_SHR:  result = a >> shamt;
            ALU_SHRA: result = $unsigned(sra_val);
            ALU_SHL:  result = a << shamt;
            ALU_ROR:  result = ror_full[WORD_W-1:0];
            ALU_ROL:  result = rol_full[2*WORD_W-1:WORD_W];
            ALU_NEG:  result = '0 - b;
            ALU_NOT:  result = ~b;
            default:  result = b;
        endcase
    end

endmodule

// File: rtl/datapath.sv
// ---------------------------------------------------------------------------
// datapath
// 32-bit single-bus CPU datapath. An external control unit drives every
// strobe; all register transfers travel over the shared bus BusMux_Out.
// Contains PC, IR, MAR, MDR, Y, ZLO, a 16x32 register file, the IR
// register-select logic, the ALU and a MEM_DEPTH x 32 RAM.
//
// Parameters:
//   MEM_DEPTH  RAM words; addressed by the low bits of MAR
//   INIT_FILE  name of the RAM image (kept for interface compatibility)
//
// Ports:
//   Clock       in   1   single clock, all state updates on posedge
//   Clear       in   1   asynchronous active-low reset of all registers
//   CONTROL     in   5   ALU opcode
//   IncPC       in   1   PC <= PC + 1
//   Read        in   1   MDR load source: 1 = RAM[MAR], 0 = bus
//   PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out   in  bus drive enables
//   PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In  in  load enables
//   G_RA, G_RB  in   1   register index from IR Ra / Rb field
//   BusMux_Out  out  32  current bus value (combinational)
// ---------------------------------------------------------------------------
module datapath
    import datapath_pkg::*;
#(
    parameter int    MEM_DEPTH = 512,
    parameter string INIT_FILE = "ram_init.hex"
) (
    input  logic              Clock,
    input  logic              Clear,
    input  logic [4:0]        CONTROL,
    input  logic              IncPC,
    input  logic              Read,
    input  logic              PC_Out,
    input  logic              MDR_Out,
    input  logic              ZLO_Out,
    input  logic              C_Out,
    input  logic              BA_Out,
    input  logic              PC_In,
    input  logic              MDR_In,
    input  logic              MAR_In,
    input  logic              IR_In,
    input  logic              Y_In,
    input  logic              ZLO_In,
    input  logic              R_In,
    input  logic              G_RA,
    input  logic              G_RB,
    output logic [WORD_W-1:0] BusMux_Out
);

    localparam int ADDR_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    // Architectural registers
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] ir;
    logic [WORD_W-1:0] mar;
    logic [WORD_W-1:0] mdr;
    logic [WORD_W-1:0] y;
    logic [WORD_W-1:0] zlo;
    logic [WORD_W-1:0] gpr [GPR_COUNT];

    // Program/data memory; never cleared by Clear
    logic [WORD_W-1:0] ram [MEM_DEPTH];

    logic [GPR_IDX_W-1:0] reg_idx;
    logic [WORD_W-1:0]    base_val;
    logic [WORD_W-1:0]    c_ext;
    logic [WORD_W-1:0]    ram_rdata;
    logic [WORD_W-1:0]    mdr_next;
    logic [WORD_W-1:0]    alu_result;

    // Only the low MAR bits address the RAM and IR[31:27] (the opcode) is
    // decoded by the external control unit, not here.
    logic unused_bits;
    assign unused_bits = ^{mar[WORD_W-1:ADDR_W], ir[WORD_W-1:27]};

    // -----------------------------------------------------------------------
    // Register select / encode: Ra takes precedence over Rb, default R0.
    // -----------------------------------------------------------------------
    always_comb begin
        reg_idx = '0;
        if (G_RA) begin
            reg_idx = ir[26:23];
        end else if (G_RB) begin
            reg_idx = ir[22:19];
        end
    end

    // R0 reads as zero when used as a base address, although it still
    // stores whatever is written into it.
    assign base_val = (reg_idx == '0) ? '0 : gpr[reg_idx];

    // Sign-extended 19-bit immediate / displacement field of IR
    assign c_ext = {{(WORD_W-19){ir[18]}}, ir[18:0]};

    // -----------------------------------------------------------------------
    // Bus multiplexer. The fixed priority makes accidental overlaps of the
    // (normally one-hot) drive enables deterministic.
    // -----------------------------------------------------------------------
    always_comb begin
        BusMux_Out = '0;
        if (MDR_Out) begin
            BusMux_Out = mdr;
        end else if (PC_Out) begin
            BusMux_Out = pc;
        end else if (ZLO_Out) begin
            BusMux_Out = zlo;
        end else if (C_Out) begin
            BusMux_Out = c_ext;
        end else if (BA_Out) begin
            BusMux_Out = base_val;
        end
    end

    // Asynchronous RAM read: MAR loaded on one edge is captured by MDR on
    // the next.
    assign ram_rdata = ram[mar[ADDR_W-1:0]];
    assign mdr_next  = Read ? ram_rdata : BusMux_Out;

    datapath_alu u_alu (
        .a      (y),
        .b      (BusMux_Out),
        .op     (CONTROL),
        .result (alu_result)
    );

    // -----------------------------------------------------------------------
    // Special-purpose registers
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            pc  <= '0;
            ir  <= '0;
            mar <= '0;
            mdr <= '0;
            y   <= '0;
            zlo <= '0;
        end else begin
            // An explicit PC load overrides the increment.
            if (PC_In) begin
                pc <= BusMux_Out;
            end else if (IncPC) begin
                pc <= pc + 1'b1;
            end
            if (IR_In) begin
                ir <= BusMux_Out;
            end
            if (MAR_In) begin
                mar <= BusMux_Out;
            end
            if (MDR_In) begin
                mdr <= mdr_next;
            end
            if (Y_In) begin
                y <= BusMux_Out;
            end
            if (ZLO_In) begin
                zlo <= alu_result;
            end
        end
    end

    // -----------------------------------------------------------------------
    // General-purpose register file
    // -----------------------------------------------------------------------
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            for (int i = 0; i < GPR_COUNT; i++) begin
                gpr[i] <= '0;
            end
        end else if (R_In) begin
            gpr[reg_idx] <= BusMux_Out;
        end
    end

endmodule

// File: tb/tb_datapath.sv
module tb_datapath;

    logic        Clock;
    logic        Clear;
    logic [4:0]  CONTROL;
    logic        IncPC, Read;
    logic        PC_Out, MDR_Out, ZLO_Out, C_Out, BA_Out;
    logic        PC_In, MDR_In, MAR_In, IR_In, Y_In, ZLO_In, R_In;
    logic        G_RA, G_RB;
    logic [31:0] BusMux_Out;

    int n_cmp;
    int n_err;

    datapath #(.MEM_DEPTH(512), .INIT_FILE("")) dut (
        .Clock(Clock), .Clear(Clear), .CONTROL(CONTROL), .IncPC(IncPC),
        .Read(Read), .PC_Out(PC_Out), .MDR_Out(MDR_Out), .ZLO_Out(ZLO_Out),
        .C_Out(C_Out), .BA_Out(BA_Out), .PC_In(PC_In), .MDR_In(MDR_In),
        .MAR_In(MAR_In), .IR_In(IR_In), .Y_In(Y_In), .ZLO_In(ZLO_In),
        .R_In(R_In), .G_RA(G_RA), .G_RB(G_RB), .BusMux_Out(BusMux_Out)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Behavioural ALU reference, written bit-by-bit from the operation rules.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        int s;
        s = int'(b[4:0]);
        r = b;
        case (op)
            5'd0:  r = a + b;
            5'd1:  r = a - b;
            5'd2:  r = a & b;
            5'd3:  r = a | b;
            5'd4:  for (int i = 0; i < 32; i++) begin
                       if (i + s < 32) r[i] = a[i + s]; else r[i] = 1'b0;
                   end
            5'd5:  for (int i = 0; i < 32; i++) begin
                       if (i + s < 32) r[i] = a[i + s]; else r[i] = a[31];
                   end
            5'd6:  for (int i = 0; i < 32; i++) begin
                       if (i >= s) r[i] = a[i - s]; else r[i] = 1'b0;
                   end
            5'd7:  for (int i = 0; i < 32; i++) r[i] = a[(i + s) % 32];
            5'd8:  for (int i = 0; i < 32; i++) r[i] = a[(i - s + 32) % 32];
            5'd9:  r = 32'd0 - b;
            5'd10: r = ~b;
            default: r = b;
        endcase
        return r;
    endfunction

    task automatic idle();
        CONTROL = 5'd0; IncPC = 0; Read = 0;
        PC_Out = 0; MDR_Out = 0; ZLO_Out = 0; C_Out = 0; BA_Out = 0;
        PC_In = 0; MDR_In = 0; MAR_In = 0; IR_In = 0; Y_In = 0; ZLO_In = 0; R_In = 0;
        G_RA = 0; G_RB = 0;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        idle();
    endtask

    task automatic poke(input logic [8:0] addr, input logic [31:0] d);
        dut.ram[addr] = d;
    endtask

    // Async Clear pulse between edges; leaves MAR = 0.
    task automatic reset_pulse();
        Clear = 0;
        #2;
        Clear = 1;
        #1;
    endtask

    // The following helpers assume MAR = 0 (true right after reset_pulse).
    task automatic load_mdr(input logic [31:0] v);
        poke(9'd0, v);
        Read = 1; MDR_In = 1;
        tick();
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        MDR_Out = 1; IR_In = 1;
        tick();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        MDR_Out = 1; Y_In = 1;
        tick();
    endtask

    task automatic test_reset();
        Clear = 0;
        idle();
        #3;
        n_cmp++;
        if (BusMux_Out !== 32'h0) begin
            n_err++; $display("FAIL reset_bus_idle: got %h expected %h", BusMux_Out, 32'h0);
        end
        @(posedge Clock); #1;
        Clear = 1;
        #1;
        PC_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0) begin
            n_err++; $display("FAIL reset_pc: got %h expected %h", BusMux_Out, 32'h0);
        end
        PC_Out = 0; ZLO_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0) begin
            n_err++; $display("FAIL reset_zlo: got %h expected %h", BusMux_Out, 32'h0);
        end
        idle();
        @(posedge Clock); #1;
    endtask

    task automatic do_fetch(input string nm, input logic [31:0] exp_ir, input logic [31:0] exp_pc);
        PC_Out = 1; MAR_In = 1; IncPC = 1;
        tick();
        Read = 1; MDR_In = 1;
        tick();
        MDR_Out = 1; IR_In = 1; #1;
        n_cmp++;
        if (BusMux_Out !== exp_ir) begin
            n_err++; $display("FAIL %s_t2_bus: got %h expected %h", nm, BusMux_Out, exp_ir);
        end
        tick();
        n_cmp++;
        if (dut.ir !== exp_ir) begin
            n_err++; $display("FAIL %s_ir: got %h expected %h", nm, dut.ir, exp_ir);
        end
        PC_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== exp_pc) begin
            n_err++; $display("FAIL %s_pc: got %h expected %h", nm, BusMux_Out, exp_pc);
        end
        idle();
    endtask

    // T3..T7 of "ld Ra, C(Rb)".
    task automatic run_ld(input string nm, input logic [31:0] exp_y, input logic [31:0] exp_addr,
                          input logic [31:0] exp_data);
        G_RB = 1; BA_Out = 1; Y_In = 1;
        tick();
        n_cmp++;
        if (dut.y !== exp_y) begin
            n_err++; $display("FAIL %s_y: got %h expected %h", nm, dut.y, exp_y);
        end
        C_Out = 1; ZLO_In = 1; CONTROL = 5'd0;
        tick();
        ZLO_Out = 1; MAR_In = 1; #1;
        n_cmp++;
        if (BusMux_Out !== exp_addr) begin
            n_err++; $display("FAIL %s_t5_bus: got %h expected %h", nm, BusMux_Out, exp_addr);
        end
        tick();
        Read = 1; MDR_In = 1;
        tick();
        MDR_Out = 1; G_RA = 1; R_In = 1; #1;
        n_cmp++;
        if (BusMux_Out !== exp_data) begin
            n_err++; $display("FAIL %s_t7_bus: got %h expected %h", nm, BusMux_Out, exp_data);
        end
        tick();
    endtask

    task automatic test_ld_direct();
        poke(9'd0, 32'h00800055);
        poke(9'd85, 32'h00000010);
        poke(9'd1, 32'h00080023);
        poke(9'd51, 32'hDEADBEEF);
        do_fetch("fetch0", 32'h00800055, 32'h1);
        run_ld("ld_r1", 32'h0, 32'h55, 32'h10);
        // R1 read back through the base-address path (IR Ra = 1)
        G_RA = 1; BA_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h10) begin
            n_err++; $display("FAIL ld_r1_value: got %h expected %h", BusMux_Out, 32'h10);
        end
        idle();
    endtask

    task automatic test_ld_indexed();
        do_fetch("fetch1", 32'h00080023, 32'h2);
        run_ld("ld_r0", 32'h10, 32'h33, 32'hDEADBEEF);
        n_cmp++;
        if (dut.gpr[0] !== 32'hDEADBEEF) begin
            n_err++; $display("FAIL ld_r0_value: got %h expected %h", dut.gpr[0], 32'hDEADBEEF);
        end
        // R0 as a base address still reads zero
        BA_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0) begin
            n_err++; $display("FAIL r0_base_zero: got %h expected %h", BusMux_Out, 32'h0);
        end
        idle();
    endtask

    task automatic test_sign_extend();
        logic [31:0] irs [3];
        logic [31:0] exps [3];
        irs[0] = 32'h0007FFFF; exps[0] = 32'hFFFFFFFF;
        irs[1] = 32'hFFC3FFFF; exps[1] = 32'h0003FFFF;
        irs[2] = 32'h00040000; exps[2] = 32'hFFFC0000;
        reset_pulse();
        for (int k = 0; k < 3; k++) begin
            load_ir(irs[k]);
            C_Out = 1; #1;
            n_cmp++;
            if (BusMux_Out !== exps[k]) begin
                n_err++; $display("FAIL sign_ext_%0d: got %h expected %h", k, BusMux_Out, exps[k]);
            end
            idle();
        end
    endtask

    task automatic test_alu_vectors();
        logic [4:0]  ops  [4];
        logic [31:0] exps [4];
        ops[0] = 5'b00001; exps[0] = 32'h4;
        ops[1] = 5'b00110; exps[1] = 32'h38;
        ops[2] = 5'b01001; exps[2] = 32'hFFFFFFFD;
        ops[3] = 5'b00111; exps[3] = 32'hE0000000;
        reset_pulse();
        load_y(32'd7);
        for (int k = 0; k < 4; k++) begin
            load_mdr(32'd3);
            MDR_Out = 1; ZLO_In = 1; CONTROL = ops[k];
            tick();
            ZLO_Out = 1; #1;
            n_cmp++;
            if (BusMux_Out !== exps[k]) begin
                n_err++; $display("FAIL alu_op%0d: got %h expected %h", ops[k], BusMux_Out, exps[k]);
            end
            idle();
        end
    endtask

    task automatic test_bus_priority();
        reset_pulse();
        load_ir(32'h0000ABCD);
        load_mdr(32'hA5A5A5A5);
        MDR_Out = 1; PC_In = 1; Y_In = 1;   // two loads from one bus value
        tick();
        MDR_Out = 1; PC_Out = 1; ZLO_Out = 1; C_Out = 1; BA_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL prio_mdr: got %h expected %h", BusMux_Out, 32'hA5A5A5A5);
        end
        load_mdr(32'h12345678);
        PC_Out = 1; ZLO_Out = 1; C_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL prio_pc: got %h expected %h", BusMux_Out, 32'hA5A5A5A5);
        end
        idle();
        ZLO_Out = 1; C_Out = 1; BA_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0) begin
            n_err++; $display("FAIL prio_zlo: got %h expected %h", BusMux_Out, 32'h0);
        end
        idle();
        C_Out = 1; BA_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0000ABCD) begin
            n_err++; $display("FAIL prio_c: got %h expected %h", BusMux_Out, 32'h0000ABCD);
        end
        idle();
        n_cmp++;
        if (dut.y !== 32'hA5A5A5A5) begin
            n_err++; $display("FAIL multi_load_y: got %h expected %h", dut.y, 32'hA5A5A5A5);
        end
    endtask

    task automatic test_pc_control();
        reset_pulse();
        load_mdr(32'h00000100);
        MDR_Out = 1; PC_In = 1; IncPC = 1;
        tick();
        PC_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h100) begin
            n_err++; $display("FAIL pc_in_wins: got %h expected %h", BusMux_Out, 32'h100);
        end
        idle();
        IncPC = 1;
        tick();
        PC_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h101) begin
            n_err++; $display("FAIL pc_inc: got %h expected %h", BusMux_Out, 32'h101);
        end
        idle();
        load_mdr(32'hFFFFFFFF);
        MDR_Out = 1; PC_In = 1;
        tick();
        IncPC = 1;
        tick();
        PC_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0) begin
            n_err++; $display("FAIL pc_wrap: got %h expected %h", BusMux_Out, 32'h0);
        end
        idle();
    endtask

    task automatic test_random_alu();
        logic [31:0] a, b, exp;
        logic [4:0]  op;
        reset_pulse();
        for (int k = 0; k < 60; k++) begin
            a  = $urandom;
            b  = $urandom;
            op = 5'($urandom_range(0, 15));
            load_y(a);
            load_mdr(b);
            MDR_Out = 1; ZLO_In = 1; CONTROL = op;
            tick();
            exp = ref_alu(op, a, b);
            ZLO_Out = 1; #1;
            n_cmp++;
            if (BusMux_Out !== exp) begin
                n_err++; $display("FAIL rand_alu op=%0d a=%h b=%h: got %h expected %h", op, a, b, BusMux_Out, exp);
            end
            idle();
        end
    endtask

    task automatic test_random_gpr();
        logic [31:0] model [16];
        logic [31:0] v, exp;
        logic [3:0]  idx, other;
        logic        use_ra;
        reset_pulse();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        for (int k = 0; k < 40; k++) begin
            idx    = 4'($urandom_range(0, 15));
            other  = 4'($urandom_range(0, 15));
            use_ra = 1'($urandom_range(0, 1));
            v      = $urandom;
            if (use_ra) load_ir({5'b0, idx, other, 19'h0});
            else        load_ir({5'b0, other, idx, 19'h0});
            load_mdr(v);
            MDR_Out = 1; R_In = 1;
            if (use_ra) G_RA = 1; else G_RB = 1;
            tick();
            model[idx] = v;
        end
        for (int i = 0; i < 16; i++) begin
            idx = 4'(i);
            load_ir({5'b0, 4'(15 - i), idx, 19'h0});
            G_RB = 1; BA_Out = 1; #1;
            exp = (i == 0) ? 32'h0 : model[i];
            n_cmp++;
            if (BusMux_Out !== exp) begin
                n_err++; $display("FAIL gpr_read_r%0d: got %h expected %h", i, BusMux_Out, exp);
            end
            // Ra takes precedence when both selects are asserted
            G_RA = 1; #1;
            exp = (i == 15) ? 32'h0 : model[15 - i];
            n_cmp++;
            if (BusMux_Out !== exp) begin
                n_err++; $display("FAIL gpr_ra_prio_r%0d: got %h expected %h", 15 - i, BusMux_Out, exp);
            end
            idle();
        end
        n_cmp++;
        if (dut.gpr[0] !== model[0]) begin
            n_err++; $display("FAIL gpr_r0_store: got %h expected %h", dut.gpr[0], model[0]);
        end
    endtask

    task automatic test_clear_midway();
        reset_pulse();
        load_mdr(32'h0BADF00D);
        MDR_Out = 1; PC_In = 1; ZLO_In = 1; CONTROL = 5'd0;
        tick();
        Clear = 0; #1;
        PC_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0) begin
            n_err++; $display("FAIL clear_pc: got %h expected %h", BusMux_Out, 32'h0);
        end
        PC_Out = 0; ZLO_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0) begin
            n_err++; $display("FAIL clear_zlo: got %h expected %h", BusMux_Out, 32'h0);
        end
        idle();
        Clear = 1;
        @(posedge Clock); #1;
        // RAM keeps its contents through Clear
        Read = 1; MDR_In = 1;
        tick();
        MDR_Out = 1; #1;
        n_cmp++;
        if (BusMux_Out !== 32'h0BADF00D) begin
            n_err++; $display("FAIL clear_ram_kept: got %h expected %h", BusMux_Out, 32'h0BADF00D);
        end
        idle();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_ld_direct();
        test_ld_indexed();
        test_sign_extend();
        test_alu_vectors();
        test_bus_priority();
        test_pc_control();
        test_random_alu();
        test_random_gpr();
        test_clear_midway();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
